// File: rtl/fp32_multiplier.sv
// Three-stage IEEE-754 binary32 multiplier (unpack, multiply, normalize/pack), truncation rounding.
// Optional macro FPM_ROUND_NEAREST_EN switches stage 3 to round-to-nearest-even.
module fp32_multiplier #(
    parameter int EXP_BIAS = 127,
    parameter int LATENCY  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out,
    output logic        overflow
);

    localparam logic [9:0] BIAS_W = 10'(EXP_BIAS);

    // Stage 1 registers: unpacked operands
    logic               s1_sign_d, s1_sign_q;
    logic               s1_zero_d, s1_zero_q;
    logic [9:0]         s1_e1_d, s1_e1_q;
    logic [9:0]         s1_e2_d, s1_e2_q;
    logic [23:0]        s1_m1_d, s1_m1_q;
    logic [23:0]        s1_m2_d, s1_m2_q;

    // Stage 2 registers: raw product and biased exponent sum
    logic               s2_sign_d, s2_sign_q;
    logic               s2_zero_d, s2_zero_q;
    logic [47:0]        s2_prod_d, s2_prod_q;
    logic signed [9:0]  s2_exp_d, s2_exp_q;

    // Stage 3 registers: packed result
    logic [31:0]        out_d, out_q;
    logic               overflow_d, overflow_q;

    // Stage 3 working values
    logic [22:0]        frac_s;
    logic signed [9:0]  exp_s;
`ifdef FPM_ROUND_NEAREST_EN
    logic               guard_s;
    logic               sticky_s;
    logic               round_up_s;
    logic [23:0]        rounded_s;
`else
    logic               unused_tail_s;
    assign unused_tail_s = ^s2_prod_q[22:0];
`endif

    // Unpack: denormals and zeros both collapse to the zero flag
    always_comb begin
        s1_sign_d = in1[31] ^ in2[31];
        s1_e1_d   = {2'b00, in1[30:23]};
        s1_e2_d   = {2'b00, in2[30:23]};
        s1_m1_d   = {1'b1, in1[22:0]};
        s1_m2_d   = {1'b1, in2[22:0]};
        if ((in1[30:23] == 8'd0) || (in2[30:23] == 8'd0)) begin
            s1_zero_d = 1'b1;
        end else begin
            s1_zero_d = 1'b0;
        end
    end

    // Multiply mantissas and combine exponents (10-bit wraparound gives the signed sum)
    always_comb begin
        s2_sign_d = s1_sign_q;
        s2_zero_d = s1_zero_q;
        s2_prod_d = {24'd0, s1_m1_q} * {24'd0, s1_m2_q};
        s2_exp_d  = $signed(s1_e1_q + s1_e2_q - BIAS_W);
    end

    // Normalize, optionally round, then select the packed result
    always_comb begin
        if (s2_prod_q[47]) begin
            frac_s = s2_prod_q[46:24];
            exp_s  = s2_exp_q + 10'sd1;
        end else begin
            frac_s = s2_prod_q[45:23];
            exp_s  = s2_exp_q;
        end

`ifdef FPM_ROUND_NEAREST_EN
        if (s2_prod_q[47]) begin
            guard_s  = s2_prod_q[23];
            sticky_s = |s2_prod_q[22:0];
        end else begin
            guard_s  = s2_prod_q[22];
            sticky_s = |s2_prod_q[21:0];
        end
        round_up_s = guard_s & (sticky_s | frac_s[0]);
        rounded_s  = {1'b0, frac_s} + {23'd0, round_up_s};
        if (rounded_s[23]) begin
            frac_s = 23'd0;
            exp_s  = exp_s + 10'sd1;
        end else begin
            frac_s = rounded_s[22:0];
        end
`endif

        if (s2_zero_q) begin
            out_d      = 32'h0000_0000;
            overflow_d = 1'b0;
        end else if (exp_s < 10'sd1) begin
            out_d      = 32'h0000_0000;
            overflow_d = 1'b0;
        end else if (exp_s > 10'sd254) begin
            out_d      = {s2_sign_q, exp_s[7:0], frac_s};
            overflow_d = 1'b1;
        end else begin
            out_d      = {s2_sign_q, exp_s[7:0], frac_s};
            overflow_d = 1'b0;
        end
    end

    // Pipeline registers: reset clears everything, enable low freezes every stage
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_e1_q    <= 10'd0;
            s1_e2_q    <= 10'd0;
            s1_m1_q    <= 24'd0;
            s1_m2_q    <= 24'd0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_prod_q  <= 48'd0;
            s2_exp_q   <= 10'sd0;
            out_q      <= 32'h0000_0000;
            overflow_q <= 1'b0;
        end else if (enable) begin
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_e1_q    <= s1_e1_d;
            s1_e2_q    <= s1_e2_d;
            s1_m1_q    <= s1_m1_d;
            s1_m2_q    <= s1_m2_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_prod_q  <= s2_prod_d;
            s2_exp_q   <= s2_exp_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end else begin
            s1_sign_q  <= s1_sign_q;
            s1_zero_q  <= s1_zero_q;
            s1_e1_q    <= s1_e1_q;
            s1_e2_q    <= s1_e2_q;
            s1_m1_q    <= s1_m1_q;
            s1_m2_q    <= s1_m2_q;
            s2_sign_q  <= s2_sign_q;
            s2_zero_q  <= s2_zero_q;
            s2_prod_q  <= s2_prod_q;
            s2_exp_q   <= s2_exp_q;
            out_q      <= out_q;
            overflow_q <= overflow_q;
        end
    end

    assign out      = out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// Directed bench for fp32_multiplier: arithmetic reference model checked every cycle,
// plus literal expectations for the listed vectors.
module tb_fp32_multiplier;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] out;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    logic chk_on = 1'b0;

    fp32_multiplier dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in1      (in1),
        .in2      (in2),
        .out      (out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: real-number style product with truncation, returns {overflow, out}
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        int                ea, eb, e;
        longint unsigned   ma, mb, p;
        logic [22:0]       f;
        logic [7:0]        ef;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return 33'd0;
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            e = e + 1;
            f = 23'((p >> 24) & 64'h7F_FFFF);
        end else begin
            f = 23'((p >> 23) & 64'h7F_FFFF);
        end
        if (e < 1) return 33'd0;
        ef = 8'(e % 256);
        return {(e > 254) ? 1'b1 : 1'b0, a[31] ^ b[31], ef, f};
    endfunction

    // Model history: operands sampled on the last two enabled edges
    logic        hv [2];
    logic [31:0] ha [2];
    logic [31:0] hb [2];
    logic [31:0] m_out = 32'd0;
    logic        m_ov  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            hv[0] = 1'b0; hv[1] = 1'b0;
            m_out = 32'd0;
            m_ov  = 1'b0;
        end else if (enable) begin
            if (hv[1]) {m_ov, m_out} = model(ha[1], hb[1]);
            else begin m_out = 32'd0; m_ov = 1'b0; end
            hv[1] = hv[0]; ha[1] = ha[0]; hb[1] = hb[0];
            hv[0] = 1'b1;  ha[0] = in1;   hb[0] = in2;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (out !== m_out || overflow !== m_ov) begin
                errors++;
                $display("FAIL model t=%0t: out=%h ov=%b, required out=%h ov=%b",
                         $time, out, overflow, m_out, m_ov);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] eo, input logic ev);
        checks++;
        if (out !== eo || overflow !== ev) begin
            errors++;
            $display("FAIL %s: out=%h ov=%b, required out=%h ov=%b", name, out, overflow, eo, ev);
        end
    endtask

    task automatic pin_model(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eo, input logic ev);
        logic [32:0] r;
        r = model(a, b);
        checks++;
        if (r !== {ev, eo}) begin
            errors++;
            $display("FAIL pin_%s: model=%h, required %h", name, r, {ev, eo});
        end
    endtask

    task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eo, input logic ev);
        @(negedge clk);
        in1 = a; in2 = b; enable = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_lit(name, eo, ev);
        pin_model(name, a, b, eo, ev);
    endtask

    logic [31:0] sa [12];
    logic [31:0] sb [12];

    initial begin
        reset = 1'b1; enable = 1'b0; in1 = 32'd0; in2 = 32'd0;
        hv[0] = 1'b0; hv[1] = 1'b0;
        @(posedge clk);
        #1 chk_on = 1'b1;
        check_lit("reset_state", 32'h0000_0000, 1'b0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;

        run_vec("trunc",      32'h40aa6666, 32'h40aa6666, 32'h41e2d850, 1'b0);
        run_vec("neg_neg",    32'hc0080000, 32'hc0680000, 32'h40f68000, 1'b0);
        run_vec("norm_shift", 32'hbf200000, 32'h3fd00000, 32'hbf820000, 1'b0);
        run_vec("identity",   32'h3f800000, 32'hc0480000, 32'hc0480000, 1'b0);
        run_vec("zero_a",     32'h00000000, 32'h40a80000, 32'h00000000, 1'b0);
        run_vec("zero_neg",   32'h00000000, 32'hc0480000, 32'h00000000, 1'b0);
        run_vec("zero_zero",  32'h00000000, 32'h00000000, 32'h00000000, 1'b0);
        run_vec("ovf_wrap",   32'h7f000000, 32'h7f000000, 32'h3e800000, 1'b1);
        run_vec("e_eq_1",     32'h00800000, 32'h3f800000, 32'h00800000, 1'b0);
        run_vec("e_eq_0",     32'h00800000, 32'h3f000000, 32'h00000000, 1'b0);
        run_vec("e_eq_254",   32'h7f000000, 32'h3f800000, 32'h7f000000, 1'b0);
        run_vec("e_eq_255",   32'h7f000000, 32'h40000000, 32'h7f800000, 1'b1);
        run_vec("denormal",   32'h00400000, 32'h3f800000, 32'h00000000, 1'b0);
        run_vec("mixed_sign", 32'h40a80000, 32'hc0440000, 32'hc180a000, 1'b0);

        // Hold: enable low with new operands must not disturb the last result
        @(negedge clk);
        enable = 1'b0; in1 = 32'h3f800000; in2 = 32'h40000000;
        repeat (3) @(posedge clk);
        #1 check_lit("hold", 32'hc180a000, 1'b0);

        // Back-to-back stream with enable gaps; the model checks each cycle
        sa = '{32'h40aa6666, 32'hc0080000, 32'hbf200000, 32'h7f000000, 32'h3f800000, 32'h00000000,
               32'h40a80000, 32'h00800000, 32'h7f000000, 32'h41200000, 32'hc2c80000, 32'h3fc00000};
        sb = '{32'h40aa6666, 32'hc0680000, 32'h3fd00000, 32'h7f000000, 32'hc0480000, 32'h40a80000,
               32'hc0440000, 32'h3f000000, 32'h40000000, 32'h41200000, 32'h3dcccccd, 32'h3fc00000};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in1 = sa[i]; in2 = sb[i];
            enable = (i % 5 != 3);
        end
        @(negedge clk) enable = 1'b1;
        repeat (4) @(posedge clk);

        // Reset with data in flight: output clears and nothing stale emerges
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in1 = sa[i]; in2 = sb[i];
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 check_lit("reset_flight", 32'h0000_0000, 1'b0);
        @(negedge clk);
        reset = 1'b0; in1 = 32'd0; in2 = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check_lit("no_stale", 32'h0000_0000, 1'b0);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
